// File: rtl/alu_seq_driver.sv
// rtl/alu_seq_driver.sv - vsync-gated single-op ALU sequencer with result accumulator
// Optional ALU_SEQ_ECHO_CHECK_EN: sticky err_o when the ALU's B echo differs from the issued B.
module alu_seq_driver #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               vsync_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [2:0]         cmd_op_i,
  input  logic               cmd_acc_i,
  input  logic [WIDTH-1:0]   cmd_a_i,
  input  logic [WIDTH-1:0]   cmd_b_i,
  output logic               en_o,
  output logic [2:0]         ctl_o,
  output logic [2*WIDTH-1:0] AB_o,
  input  logic [2*WIDTH-1:0] BC_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [WIDTH-1:0]   res_o,
  output logic               busy_o,
  output logic               err_o
);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ISSUE, RESP} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic [2:0]         ctl_q, ctl_d;
  logic [2*WIDTH-1:0] ab_q, ab_d;
`ifdef ALU_SEQ_ECHO_CHECK_EN
  logic               err_q, err_d;
`else
  logic               unused_echo;
  assign unused_echo = ^BC_i[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    ctl_d       = ctl_q;
    ab_d        = ab_q;
`ifdef ALU_SEQ_ECHO_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        // Operands land in the ALU-facing registers here, so they are stable well before en_o.
        if (cmd_valid_i) begin
          ctl_d   = cmd_op_i;
          ab_d    = {(cmd_acc_i ? acc_q : cmd_a_i), cmd_b_i};
          state_d = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (vsync_i) state_d = ISSUE;
      end
      ISSUE: begin
        res_d       = BC_i[WIDTH-1:0];
        acc_d       = BC_i[WIDTH-1:0];
        res_valid_d = 1'b1;
        state_d     = RESP;
`ifdef ALU_SEQ_ECHO_CHECK_EN
        if (BC_i[2*WIDTH-1:WIDTH] != ab_q[WIDTH-1:0]) err_d = 1'b1;
`endif
      end
      RESP: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      ctl_q       <= '0;
      ab_q        <= '0;
`ifdef ALU_SEQ_ECHO_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      ctl_q       <= ctl_d;
      ab_q        <= ab_d;
`ifdef ALU_SEQ_ECHO_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign en_o        = (state_q == ISSUE);
  assign ctl_o       = ctl_q;
  assign AB_o        = ab_q;
  assign res_o       = res_q;
  assign res_valid_o = res_valid_q;
`ifdef ALU_SEQ_ECHO_CHECK_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_driver.sv
// tb/tb_alu_seq_driver.sv - scoreboard bench for alu_seq_driver with a behavioural ALU and accumulator model
module tb_alu_seq_driver;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           vsync_i = 1'b0;
  logic           cmd_valid_i = 1'b0;
  logic           cmd_ready_o;
  logic [2:0]     cmd_op_i = '0;
  logic           cmd_acc_i = 1'b0;
  logic [W-1:0]   cmd_a_i = '0;
  logic [W-1:0]   cmd_b_i = '0;
  logic           en_o;
  logic [2:0]     ctl_o;
  logic [2*W-1:0] AB_o;
  logic [2*W-1:0] BC_i;
  logic           res_valid_o;
  logic           res_ready_i = 1'b0;
  logic [W-1:0]   res_o;
  logic           busy_o;
  logic           err_o;
  logic           corrupt = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]     model_acc = '0;
  logic [W-1:0]     last_exp;
  logic [W-1:0]     exp_res_q[$];
  logic [3+2*W-1:0] exp_iss_q[$];
  logic             en_prev = 1'b0;

`ifdef ALU_SEQ_ECHO_CHECK_EN
  localparam logic ECHO_ERR = 1'b1;
`else
  localparam logic ECHO_ERR = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  function automatic logic [W-1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return '0;
      3'd1: return a;
      3'd2: return b;
      3'd3: return a - b;
      3'd4: return a + b;
      3'd5: return a ^ b;
      3'd6: return a & b;
      default: return a | b;
    endcase
  endfunction

  // Combinational ALU: echoes B in the upper half unless corrupted.
  assign BC_i = {(corrupt ? {W{1'b0}} : AB_o[W-1:0]), alu_ref(ctl_o, AB_o[2*W-1:W], AB_o[W-1:0])};

  alu_seq_driver #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .vsync_i(vsync_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_acc_i(cmd_acc_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .en_o(en_o), .ctl_o(ctl_o), .AB_o(AB_o), .BC_i(BC_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: issue and result scoreboards, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      en_prev = 1'b0;
    end else begin
      if (en_o) begin
        if (exp_iss_q.size() == 0) check("unexpected_en_o", 1, 0);
        else begin
          logic [3+2*W-1:0] e;
          e = exp_iss_q.pop_front();
          check("issue_ctl", ctl_o, e[2*W+2:2*W]);
          check("issue_ab", AB_o, e[2*W-1:0]);
        end
      end
      if (en_prev) check("res_valid_after_en", res_valid_o, 1);
      if (res_valid_o && res_ready_i) begin
        if (exp_res_q.size() == 0) check("unexpected_result", 1, 0);
        else check("res_value", res_o, exp_res_q.pop_front());
      end
      en_prev = en_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic acc, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic vs_in_accept);
    logic [W-1:0] a_eff;
    int n = 0;
    while (!cmd_ready_o && n < 50) begin
      step();
      n++;
    end
    check("cmd_ready_wait", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_acc_i   = acc;
    cmd_a_i     = a;
    cmd_b_i     = b;
    vsync_i     = vs_in_accept;
    a_eff       = acc ? model_acc : a;
    last_exp    = alu_ref(op, a_eff, b);
    model_acc   = last_exp;
    exp_iss_q.push_back({op, a_eff, b});
    exp_res_q.push_back(last_exp);
    step();
    cmd_valid_i = 1'b0;
    vsync_i     = 1'b0;
    cmd_a_i     = W'($urandom);
    cmd_b_i     = W'($urandom);
    check("busy_after_accept", busy_o, 1);
    check("cmd_ready_low_after_accept", cmd_ready_o, 0);
  endtask

  task automatic do_op(input logic [2:0] op, input logic acc, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int vs_delay, input int rdy_delay, input logic vs_in_accept);
    send_cmd(op, acc, a, b, vs_in_accept);
    repeat (vs_delay) begin
      check("no_en_before_vsync", en_o, 0);
      check("busy_waiting", busy_o, 1);
      step();
    end
    vsync_i = 1'b1;
    check("no_en_before_vsync", en_o, 0);
    step();
    vsync_i = 1'b0;
    check("en_o_pulse", en_o, 1);
    step();
    check("en_o_single", en_o, 0);
    check("res_valid_set", res_valid_o, 1);
    repeat (rdy_delay) begin
      check("res_valid_hold", res_valid_o, 1);
      check("res_hold", res_o, last_exp);
      check("cmd_ready_before_hs", cmd_ready_o, 0);
      step();
    end
    res_ready_i = 1'b1;
    step();
    res_ready_i = 1'b0;
    check("res_valid_cleared", res_valid_o, 0);
    check("cmd_ready_after_hs", cmd_ready_o, 1);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    exp_iss_q.delete();
    exp_res_q.delete();
    model_acc = '0;
    #2;
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_en", en_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_ctl", ctl_o, 0);
    check("rst_ab", AB_o, 0);
    check("rst_res", res_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // Add with carry out of bit 6, vsync three cycles after acceptance.
    do_op(3'd4, 1'b0, 8'h7F, 8'h01, 3, 0, 1'b0);

    // Accumulator chain with modulo wrap.
    do_op(3'd4, 1'b0, 8'hF0, 8'h20, 1, 0, 1'b0);
    do_op(3'd4, 1'b1, 8'hAA, 8'h10, 0, 0, 1'b0);

    // vsync coinciding with acceptance must not issue; the next one ten cycles later does.
    do_op(3'd7, 1'b0, 8'h0F, 8'h30, 9, 0, 1'b1);

    // Result back-pressure for five cycles.
    do_op(3'd3, 1'b0, 8'h05, 8'h09, 2, 5, 1'b0);

    // Reset while waiting for vsync drops the op and clears the accumulator.
    send_cmd(3'd4, 1'b0, 8'h12, 8'h34, 1'b0);
    step();
    apply_reset();
    check("post_rst_cmd_ready", cmd_ready_o, 1);
    check("post_rst_res_valid", res_valid_o, 0);
    vsync_i = 1'b1;
    step();
    vsync_i = 1'b0;
    repeat (3) begin
      check("no_en_after_reset", en_o, 0);
      step();
    end
    do_op(3'd4, 1'b1, 8'hEE, 8'h05, 0, 0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      do_op(3'($urandom), 1'($urandom), W'($urandom), W'($urandom),
            $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom));
    end
    check("err_clean_traffic", err_o, 0);

    // Corrupted B echo.
    corrupt = 1'b1;
    do_op(3'd4, 1'b0, 8'h11, 8'h55, 1, 0, 1'b0);
    corrupt = 1'b0;
    check("err_after_bad_echo", err_o, ECHO_ERR);
    do_op(3'd5, 1'b0, 8'h3C, 8'h55, 0, 1, 1'b0);
    check("err_sticky", err_o, ECHO_ERR);
    apply_reset();
    check("err_cleared_by_reset", err_o, 0);
    step();

    check("res_queue_drained", exp_res_q.size(), 0);
    check("iss_queue_drained", exp_iss_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
